mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of data bus.
REQ-002 SHALL have parameter ADDR_W, default 16, width of address bus.
REQ-003 SHALL have parameter DEPTH, default 256, number of implemented memory words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, extra cycles strobes are held beyond the first (legal range 0..15).
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clock  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have req_valid  input  1  request present.
REQ-007 SHALL have req_ready  output  1  controller can accept a request.
REQ-008 SHALL have req_write  input  1  1=write, 0=read.
REQ-009 SHALL have req_addr  input  ADDR_W  word address.
REQ-010 SHALL have req_wdata  input  DATA_W  write data.
REQ-011 SHALL have rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have rsp_data  output  DATA_W  read data.
REQ-013 SHALL have rsp_err  output  1  address error, qualified by rsp_valid.
REQ-014 SHALL have MemRead, MemWrite  output  1 each  memory strobes.
REQ-015 SHALL have MemIn  output  ADDR_W  memory address; WriteData  output  DATA_W  memory write data.
REQ-016 SHALL have MemOut  input  DATA_W  memory read data.

Function
REQ-017 SHALL implement states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready, latching req_write, req_addr, req_wdata and entering ACCESS.
REQ-019 SHALL ignore req_valid in ACCESS and RESP; no queuing.
REQ-020 SHALL, in ACCESS, drive MemIn=latched address, WriteData=latched data, and exactly one of MemRead/MemWrite per req_write for WAIT_CYCLES+1 consecutive cycles, then enter RESP.
REQ-021 SHALL drive MemRead, MemWrite, MemIn, WriteData from registers only (glitch-free); MemRead and MemWrite never high together.
REQ-022 SHALL, for reads, capture MemOut into rsp_data on the edge that ends the last ACCESS cycle.
REQ-023 SHALL, for writes, leave rsp_data unchanged.
REQ-024 SHALL, in RESP, deassert both strobes, hold MemIn/WriteData unchanged, assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-025 SHALL give latency: accept at edge N, rsp_valid high in cycle N+2+WAIT_CYCLES; next accept no earlier than edge N+3+WAIT_CYCLES.
REQ-026 SHALL keep rsp_err=0 except per REQ-031.

Reset
REQ-027 SHALL, while reset is high, asynchronously force state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, MemRead=0, MemWrite=0, MemIn=0, WriteData=0, counter=0.
REQ-028 SHALL abort any in-flight access on reset with no rsp_valid; requests are not accepted while reset is high.
REQ-029 SHALL accept a request on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL use macro MEMCTRL_ADDR_CHECK_EN to compile in address range checking.
REQ-031 SHALL, with MEMCTRL_ADDR_CHECK_EN defined, send an accepted request with req_addr >= DEPTH directly IDLE->RESP, with no strobe asserted, rsp_err=1 with rsp_valid, rsp_data unchanged, latency N+1.
REQ-032 SHALL, without MEMCTRL_ADDR_CHECK_EN, tie rsp_err to 0 and pass every address to the memory unchanged.

Verification
REQ-033 SHALL cover: write addr 0x0010 data 0xBEEF, then read 0x0010 -> MemWrite high for 2 cycles, then rsp_data=0xBEEF at the read's rsp_valid.
REQ-034 SHALL cover: read with WAIT_CYCLES=0 and with WAIT_CYCLES=3 -> rsp_valid at N+2 and N+5, with strobe widths 1 and 4 cycles.
REQ-035 SHALL cover: req_valid held high continuously -> one accept per 3+WAIT_CYCLES cycles, req_ready low in ACCESS/RESP, and strobes never overlapping.
REQ-036 SHALL cover: reset asserted in the middle of an ACCESS write -> MemWrite drops to 0 immediately without a clock edge, and no rsp_valid.
REQ-037 SHALL cover: with MEMCTRL_ADDR_CHECK_EN, read 0x0100 (DEPTH=256) -> rsp_valid and rsp_err=1 at N+1 with no strobe; read 0x00FF -> normal read with rsp_err=0.
REQ-038 SHALL cover: write followed by a read -> rsp_data retains the prior read value after the write's rsp_valid.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundles the request/response handshake and the memory-side bus of mem_access_ctrl.
// The master modport is the requester plus memory environment; the slave modport is the controller.
interface mem_access_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              MemRead;
   logic              MemWrite;
   logic [ADDR_W-1:0] MemIn;
   logic [DATA_W-1:0] WriteData;
   logic [DATA_W-1:0] MemOut;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, MemOut,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  MemRead, MemWrite, MemIn, WriteData
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, MemOut,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output MemRead, MemWrite, MemIn, WriteData
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access controller with registered strobes and a stretchable access phase.
// Define MEMCTRL_ADDR_CHECK_EN to reject addresses >= DEPTH with rsp_err instead of touching memory.
module mem_access_ctrl #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input logic             clock,
   input logic             reset,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES);

   state_t            state, state_n;
   logic [3:0]        count, count_n;
   logic              mem_read, mem_read_n;
   logic              mem_write, mem_write_n;
   logic [ADDR_W-1:0] mem_in, mem_in_n;
   logic [DATA_W-1:0] write_data, write_data_n;
   logic [DATA_W-1:0] rsp_data, rsp_data_n;
   logic              rsp_err, rsp_err_n;
   logic              addr_bad;

`ifdef MEMCTRL_ADDR_CHECK_EN
   assign addr_bad = (32'(bus.req_addr) >= 32'(DEPTH));
`else
   logic [31:0] depth_unused;
   assign depth_unused = 32'(DEPTH);
   assign addr_bad     = 1'b0;
`endif

   // Every memory-facing output is a flop so the strobes never glitch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= 4'd0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_in     <= '0;
         write_data <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         mem_read   <= mem_read_n;
         mem_write  <= mem_write_n;
         mem_in     <= mem_in_n;
         write_data <= write_data_n;
         rsp_data   <= rsp_data_n;
         rsp_err    <= rsp_err_n;
      end
   end

   always_comb begin
      state_n      = state;
      count_n      = count;
      mem_read_n   = mem_read;
      mem_write_n  = mem_write;
      mem_in_n     = mem_in;
      write_data_n = write_data;
      rsp_data_n   = rsp_data;
      rsp_err_n    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (addr_bad) begin
                  state_n   = RESP;
                  rsp_err_n = 1'b1;
               end else begin
                  state_n      = ACCESS;
                  count_n      = 4'd0;
                  mem_read_n   = !bus.req_write;
                  mem_write_n  = bus.req_write;
                  mem_in_n     = bus.req_addr;
                  write_data_n = bus.req_wdata;
               end
            end
         end
         ACCESS: begin
            // Strobes drop and read data is captured on the same edge that leaves ACCESS.
            if (count == LAST_COUNT) begin
               state_n     = RESP;
               mem_read_n  = 1'b0;
               mem_write_n = 1'b0;
               if (mem_read) begin
                  rsp_data_n = bus.MemOut;
               end
            end else begin
               count_n = count + 4'd1;
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_data  = rsp_data;
   assign bus.rsp_err   = rsp_err;
   assign bus.MemRead   = mem_read;
   assign bus.MemWrite  = mem_write;
   assign bus.MemIn     = mem_in;
   assign bus.WriteData = write_data;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: three instances with WAIT_CYCLES 1, 0 and 3 share clock and reset.
// Instance 0 talks to a 256-word memory model; the others see MemIn ^ 16'h5A5A as read data.
module tb_mem_access_ctrl;
   logic clock;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;

   logic        req_valid_v [3];
   logic        req_write_v [3];
   logic [15:0] req_addr_v  [3];
   logic [15:0] req_wdata_v [3];
   logic        req_ready_v [3];
   logic        rsp_valid_v [3];
   logic [15:0] rsp_data_v  [3];
   logic        rsp_err_v   [3];
   logic        mem_read_v  [3];
   logic        mem_write_v [3];
   logic [15:0] mem_in_v    [3];
   logic [15:0] write_data_v[3];

   int strobe_cnt[3];
   int rsp_cnt[3];
   bit overlap[3];
   bit busy_ready[3];

   logic [15:0] mem [256];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();
      assign bus.req_valid    = req_valid_v[g];
      assign bus.req_write    = req_write_v[g];
      assign bus.req_addr     = req_addr_v[g];
      assign bus.req_wdata    = req_wdata_v[g];
      assign req_ready_v[g]   = bus.req_ready;
      assign rsp_valid_v[g]   = bus.rsp_valid;
      assign rsp_data_v[g]    = bus.rsp_data;
      assign rsp_err_v[g]     = bus.rsp_err;
      assign mem_read_v[g]    = bus.MemRead;
      assign mem_write_v[g]   = bus.MemWrite;
      assign mem_in_v[g]      = bus.MemIn;
      assign write_data_v[g]  = bus.WriteData;
      if (g == 0) begin : g_mem
         assign bus.MemOut = mem[bus.MemIn[7:0]];
      end else begin : g_pat
         assign bus.MemOut = bus.MemIn ^ 16'h5A5A;
      end
      mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(W)) dut (
         .clock(clock),
         .reset(reset),
         .bus  (bus)
      );
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory contents restart from a known pattern whenever reset is high.
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
      end else if (mem_write_v[0]) begin
         mem[mem_in_v[0][7:0]] <= write_data_v[0];
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            strobe_cnt[k] <= strobe_cnt[k] + ((mem_read_v[k] || mem_write_v[k]) ? 1 : 0);
            if (rsp_valid_v[k]) rsp_cnt[k] <= rsp_cnt[k] + 1;
            if (mem_read_v[k] && mem_write_v[k]) overlap[k] <= 1'b1;
            if (req_ready_v[k] && (mem_read_v[k] || mem_write_v[k] || rsp_valid_v[k])) busy_ready[k] <= 1'b1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one request on instance k; lat is (edge ending the rsp_valid cycle) - (accept edge).
   task automatic applyStimulus(input int k, input logic wr, input logic [15:0] addr,
                                input logic [15:0] data, output int lat, output int strobes,
                                output logic [15:0] rdata, output logic err);
      int  acc = 0;
      int  s0  = 0;
      bit  got = 0;
      lat = 0; strobes = 0; rdata = '0; err = 1'b0;
      @(posedge clock); #1;
      req_valid_v[k] = 1'b1; req_write_v[k] = wr; req_addr_v[k] = addr; req_wdata_v[k] = data;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         if (req_ready_v[k]) begin acc = cyc + 1; s0 = strobe_cnt[k]; got = 1; end
      end
      @(posedge clock); #1;
      req_valid_v[k] = 1'b0;
      if (!got) begin checkOutput("accept_timeout", 0, 1); return; end
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock);
         if (rsp_valid_v[k]) begin lat = cyc + 1 - acc; rdata = rsp_data_v[k]; err = rsp_err_v[k]; got = 1; end
      end
      if (!got) begin checkOutput("rsp_timeout", 0, 1); return; end
      @(negedge clock);
      strobes = strobe_cnt[k] - s0;
      checkOutput("rsp_one_cycle", 32'(rsp_valid_v[k]), 0);
   endtask

   int          lat, strobes, acc_n, r0, r1, rel, acc_edge;
   int          acc_q[$];
   logic [15:0] rdata;
   logic        err;

   initial begin
      cyc = 0; checks = 0; failures = 0;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_valid_v[k] = 1'b0; req_write_v[k] = 1'b0; req_addr_v[k] = '0; req_wdata_v[k] = '0;
      end
      repeat (3) @(posedge clock);
      #2;
      checkOutput("rst_ready",     32'(req_ready_v[0]), 1);
      checkOutput("rst_rsp_valid", 32'(rsp_valid_v[0]), 0);
      checkOutput("rst_rsp_data",  32'(rsp_data_v[0]), 0);
      checkOutput("rst_rsp_err",   32'(rsp_err_v[0]), 0);
      checkOutput("rst_strobes",   {30'd0, mem_read_v[0], mem_write_v[0]}, 0);
      checkOutput("rst_mem_in",    32'(mem_in_v[0]), 0);
      checkOutput("rst_wdata",     32'(write_data_v[0]), 0);
      reset = 1'b0;

      applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF, lat, strobes, rdata, err);
      checkOutput("wr_latency", 32'(lat), 3);
      checkOutput("wr_strobe_width", 32'(strobes), 2);
      checkOutput("wr_rsp_data_kept", 32'(rdata), 0);
      checkOutput("wr_err", 32'(err), 0);
      checkOutput("wr_mem_contents", 32'(mem[16]), 32'hBEEF);
      checkOutput("wr_mem_in_held", 32'(mem_in_v[0]), 32'h0010);
      checkOutput("wr_wdata_held", 32'(write_data_v[0]), 32'hBEEF);

      applyStimulus(0, 1'b0, 16'h0010, 16'h0000, lat, strobes, rdata, err);
      checkOutput("rd_latency", 32'(lat), 3);
      checkOutput("rd_strobe_width", 32'(strobes), 2);
      checkOutput("rd_data", 32'(rdata), 32'hBEEF);

      applyStimulus(0, 1'b0, 16'h0020, 16'h0000, lat, strobes, rdata, err);
      checkOutput("rd2_data", 32'(rdata), 32'hA585);
      applyStimulus(0, 1'b1, 16'h0030, 16'h1234, lat, strobes, rdata, err);
      checkOutput("wr2_rsp_data_kept", 32'(rdata), 32'hA585);
      checkOutput("wr2_rsp_data_after", 32'(rsp_data_v[0]), 32'hA585);

      applyStimulus(1, 1'b0, 16'h0005, 16'h0000, lat, strobes, rdata, err);
      checkOutput("w0_latency", 32'(lat), 2);
      checkOutput("w0_strobe_width", 32'(strobes), 1);
      checkOutput("w0_data", 32'(rdata), 32'h5A5F);

      applyStimulus(2, 1'b0, 16'h0007, 16'h0000, lat, strobes, rdata, err);
      checkOutput("w3_latency", 32'(lat), 5);
      checkOutput("w3_strobe_width", 32'(strobes), 4);
      checkOutput("w3_data", 32'(rdata), 32'h5A5D);

      // Continuous req_valid on instance 0: one accept every 4 cycles.
      r0 = rsp_cnt[0]; r1 = strobe_cnt[0];
      @(posedge clock); #1;
      req_valid_v[0] = 1'b1; req_write_v[0] = 1'b0; req_addr_v[0] = 16'h0010;
      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         if (req_ready_v[0]) acc_q.push_back(cyc + 1);
      end
      @(posedge clock); #1;
      req_valid_v[0] = 1'b0;
      repeat (8) @(negedge clock);
      acc_n = acc_q.size();
      checkOutput("stream_accepts", 32'(acc_n), 4);
      for (int i = 1; i < acc_n; i++) checkOutput("stream_gap", 32'(acc_q[i] - acc_q[i-1]), 4);
      checkOutput("stream_rsp_count", 32'(rsp_cnt[0] - r0), 32'(acc_n));
      checkOutput("stream_strobe_cycles", 32'(strobe_cnt[0] - r1), 32'(2 * acc_n));

      // Reset in the middle of a write on instance 2, then a request waiting on instance 1.
      @(posedge clock); #1;
      req_valid_v[2] = 1'b1; req_write_v[2] = 1'b1; req_addr_v[2] = 16'h0040; req_wdata_v[2] = 16'h7777;
      @(posedge clock); #1;
      req_valid_v[2] = 1'b0;
      @(posedge clock); #2;
      checkOutput("abort_wr_before", 32'(mem_write_v[2]), 1);
      r0 = rsp_cnt[2]; r1 = rsp_cnt[1];
      reset = 1'b1;
      #1;
      checkOutput("abort_wr_async_drop", 32'(mem_write_v[2]), 0);
      checkOutput("abort_ready", 32'(req_ready_v[2]), 1);
      @(posedge clock); #1;
      req_valid_v[1] = 1'b1; req_write_v[1] = 1'b0; req_addr_v[1] = 16'h0009;
      @(posedge clock); #2;
      rel = cyc + 1;
      reset = 1'b0;
      acc_edge = 0;
      for (int i = 0; i < 10 && acc_edge == 0; i++) begin
         @(negedge clock);
         if (req_ready_v[1]) acc_edge = cyc + 1;
      end
      @(posedge clock); #1;
      req_valid_v[1] = 1'b0;
      checkOutput("first_edge_accept", 32'(acc_edge), 32'(rel));
      repeat (8) @(negedge clock);
      checkOutput("abort_no_rsp", 32'(rsp_cnt[2] - r0), 0);
      checkOutput("post_rst_rsp", 32'(rsp_cnt[1] - r1), 1);
      checkOutput("post_rst_mem_in", 32'(mem_in_v[2]), 0);
      checkOutput("post_rst_rsp_data", 32'(rsp_data_v[0]), 0);

`ifdef MEMCTRL_ADDR_CHECK_EN
      applyStimulus(0, 1'b0, 16'h0100, 16'h0000, lat, strobes, rdata, err);
      checkOutput("oob_latency", 32'(lat), 1);
      checkOutput("oob_strobes", 32'(strobes), 0);
      checkOutput("oob_err", 32'(err), 1);
      checkOutput("oob_rsp_data_kept", 32'(rdata), 0);
      applyStimulus(0, 1'b0, 16'h00FF, 16'h0000, lat, strobes, rdata, err);
      checkOutput("edge_latency", 32'(lat), 3);
      checkOutput("edge_strobes", 32'(strobes), 2);
      checkOutput("edge_err", 32'(err), 0);
      checkOutput("edge_data", 32'(rdata), 32'hA55A);
`else
      applyStimulus(0, 1'b0, 16'h0100, 16'h0000, lat, strobes, rdata, err);
      checkOutput("nochk_latency", 32'(lat), 3);
      checkOutput("nochk_strobes", 32'(strobes), 2);
      checkOutput("nochk_err", 32'(err), 0);
      checkOutput("nochk_mem_in", 32'(mem_in_v[0]), 32'h0100);
      checkOutput("nochk_data", 32'(rdata), 32'hA5A5);
`endif

      for (int k = 0; k < 3; k++) begin
         checkOutput("strobe_overlap", 32'(overlap[k]), 0);
         checkOutput("ready_while_busy", 32'(busy_ready[k]), 0);
      end

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: observed no end, expected $finish");
      $fatal(1, "[TB] timeout");
   end
endmodule
